// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RISC-V control sequencer: states,
// opcodes, mux selects and the decoded control word.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // irWrite/pcUpdate are raw; the top qualifies them with MemReady in FETCH
  typedef struct packed {
    logic       memReq;
    logic       irWrite;
    logic       adrSrc;
    logic       memWrite;
    logic       regWrite;
    logic       pcUpdate;
    logic       branch;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] resultSrc;
  } ctrl_t;

  function automatic logic [1:0] immSrcOf(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Combinational state -> control-word decode for the multicycle sequencer,
// plus the immediate-format select taken straight from the opcode.
module mc_ctrl_outputs
  import riscv_mc_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] op,
  output ctrl_t      ctrl,
  output logic [1:0] immSrc
);

  assign immSrc = immSrcOf(op);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memReq    = 1'b1;
        ctrl.irWrite   = 1'b1;
        ctrl.pcUpdate  = 1'b1;
        ctrl.aluSrcA   = SRCA_PC;
        ctrl.aluSrcB   = SRCB_FOUR;
        ctrl.aluOp     = ALUOP_ADD;
        ctrl.resultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ctrl.aluSrcA = SRCA_OLDPC;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.aluSrcA = SRCA_RS1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.memReq = 1'b1;
        ctrl.adrSrc = 1'b1;
      end
      S_MEMWB: begin
        ctrl.resultSrc = RES_DATA;
        ctrl.regWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.memReq   = 1'b1;
        ctrl.adrSrc   = 1'b1;
        ctrl.memWrite = 1'b1;
      end
      S_EXECR: begin
        ctrl.aluSrcA = SRCA_RS1;
        ctrl.aluSrcB = SRCB_RS2;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl.aluSrcA = SRCA_RS1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      S_JAL: begin
        ctrl.aluSrcA  = SRCA_OLDPC;
        ctrl.aluSrcB  = SRCB_FOUR;
        ctrl.aluOp    = ALUOP_ADD;
        ctrl.pcUpdate = 1'b1;
      end
      S_ALUWB: begin
        ctrl.resultSrc = RES_ALUOUT;
        ctrl.regWrite  = 1'b1;
      end
      S_BEQ: begin
        ctrl.aluSrcA = SRCA_RS1;
        ctrl.aluSrcB = SRCB_RS2;
        ctrl.aluOp   = ALUOP_SUB;
        ctrl.branch  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RISC-V control sequencer: state register, next-state, MemReady
// gating and retire counter. Define ILLEGAL_OP_TRAP_EN to trap unsupported ops.
//
// state    | meaning
// FETCH    | read instruction at PC, wait for MemReady
// DECODE   | classify Op, precompute branch target
// MEMADR   | compute lw/sw address
// MEMREAD  | load access, wait for MemReady
// MEMWB    | write load data to register file
// MEMWRITE | store access, wait for MemReady
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// JAL      | jump, link value computed
// ALUWB    | write ALU result to register file
// BEQ      | compare and conditionally branch
// TRAP     | unsupported Op seen, held until rst
module multicycle_ctrl_fsm
  import riscv_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       Op,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ImmSrc,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] RetireCnt,
  output logic             Illegal
);

  state_t state;
  state_t stateNext;
  ctrl_t  ctrl;
  logic   retire;
  logic   pcUpdate;

  mc_ctrl_outputs uCtrlOutputs (
    .state  (state),
    .op     (Op),
    .ctrl   (ctrl),
    .immSrc (ImmSrc)
  );

  always_comb begin
    stateNext = state;
    case (state)
      S_FETCH:    if (MemReady) stateNext = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: stateNext = S_MEMADR;
          OP_R:         stateNext = S_EXECR;
          OP_I:         stateNext = S_EXECI;
          OP_BEQ:       stateNext = S_BEQ;
          OP_JAL:       stateNext = S_JAL;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      stateNext = S_TRAP;
`else
          default:      stateNext = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   stateNext = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (MemReady) stateNext = S_MEMWB;
      S_MEMWRITE: if (MemReady) stateNext = S_FETCH;
      S_EXECR, S_EXECI, S_JAL: stateNext = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ: stateNext = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:     stateNext = S_TRAP;
`endif
      default:    stateNext = S_FETCH;
    endcase
  end

  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                  ((state == S_MEMWRITE) && MemReady);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      RetireCnt <= '0;
    end else begin
      state <= stateNext;
      if (retire) RetireCnt <= RetireCnt + CNT_W'(1);
    end
  end

  // FETCH only completes (IR load, PC+4) in the cycle memory answers
  assign pcUpdate = ctrl.pcUpdate & ((state != S_FETCH) | MemReady);

  assign MemReq    = ctrl.memReq & ~rst;
  assign IRWrite   = ctrl.irWrite & MemReady & ~rst;
  assign MemWrite  = ctrl.memWrite & ~rst;
  assign RegWrite  = ctrl.regWrite & ~rst;
  assign PCWrite   = (pcUpdate | (ctrl.branch & Zero)) & ~rst;
  assign AdrSrc    = ctrl.adrSrc;
  assign Branch    = ctrl.branch;
  assign ALUSrcA   = ctrl.aluSrcA;
  assign ALUSrcB   = ctrl.aluSrcB;
  assign ALUOp     = ctrl.aluOp;
  assign ResultSrc = ctrl.resultSrc;
  assign State     = state;

`ifdef ILLEGAL_OP_TRAP_EN
  assign Illegal = (state == S_TRAP);
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm: instructions are expanded into
// expected per-cycle phase traces and every cycle is compared against them.
module tb_multicycle_ctrl_fsm;

  localparam int CNT_W = 32;

  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] BQ = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;

  localparam logic [14:0] RESET_WORD = {7'b0, 2'b00, 2'b10, 2'b00, 2'b10};

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       Op;
  logic             Zero;
  logic             MemReady;
  logic             MemReq, IRWrite, AdrSrc, MemWrite, RegWrite, PCWrite, Branch;
  logic [1:0]       ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc;
  logic [3:0]       State;
  logic [CNT_W-1:0] RetireCnt;
  logic             Illegal;

  multicycle_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .Op        (Op),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .MemReq    (MemReq),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .RegWrite  (RegWrite),
    .PCWrite   (PCWrite),
    .Branch    (Branch),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ResultSrc (ResultSrc),
    .ImmSrc    (ImmSrc),
    .State     (State),
    .RetireCnt (RetireCnt),
    .Illegal   (Illegal)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nBad = 0;
  logic [CNT_W-1:0] expCnt;

  typedef struct {
    int   st;
    logic rdy;
  } cyc_t;

  cyc_t trace[$];

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit isLegal(input logic [6:0] op);
    return (op == LW) || (op == SW) || (op == RT) || (op == IT) || (op == BQ) || (op == JL);
  endfunction

  function automatic logic [1:0] immExp(input logic [6:0] op);
    if (op == SW) return 2'b01;
    if (op == BQ) return 2'b10;
    if (op == JL) return 2'b11;
    return 2'b00;
  endfunction

  // Expected control word for one phase, written from the per-state output table
  function automatic logic [14:0] expCtrl(input int st, input logic rdy, input logic z);
    logic mq, ir, ad, mw, rw, pcu, br;
    logic [1:0] a, b, o, r;
    {mq, ir, ad, mw, rw, pcu, br} = 7'b0;
    {a, b, o, r} = 8'b0;
    case (st)
      0:  begin mq = 1; ir = rdy; pcu = rdy; b = 2'b10; r = 2'b10; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  begin mq = 1; ad = 1; end
      4:  begin r = 2'b01; rw = 1; end
      5:  begin mq = 1; ad = 1; mw = 1; end
      6:  begin a = 2'b10; o = 2'b10; end
      7:  begin a = 2'b10; b = 2'b01; o = 2'b10; end
      8:  begin a = 2'b01; b = 2'b10; pcu = 1; end
      9:  rw = 1;
      10: begin a = 2'b10; o = 2'b01; br = 1; end
      default: ;
    endcase
    return {mq, ir, ad, mw, rw, pcu | (br & z), br, a, b, o, r};
  endfunction

  function automatic logic [14:0] dutCtrl();
    return {MemReq, IRWrite, AdrSrc, MemWrite, RegWrite, PCWrite, Branch,
            ALUSrcA, ALUSrcB, ALUOp, ResultSrc};
  endfunction

  function automatic void pushWait(input int st, input int waits);
    for (int w = 0; w < waits; w++) trace.push_back('{st: st, rdy: 1'b0});
    trace.push_back('{st: st, rdy: 1'b1});
  endfunction

  function automatic void pushOne(input int st);
    trace.push_back('{st: st, rdy: 1'($urandom)});
  endfunction

  function automatic void buildTrace(input logic [6:0] op, input int fw, input int mw);
    trace.delete();
    pushWait(0, fw);
    pushOne(1);
    case (op)
      LW: begin pushOne(2); pushWait(3, mw); pushOne(4); end
      SW: begin pushOne(2); pushWait(5, mw); end
      RT: begin pushOne(6); pushOne(9); end
      IT: begin pushOne(7); pushOne(9); end
      JL: begin pushOne(8); pushOne(9); end
      BQ: pushOne(10);
      default: begin
`ifdef ILLEGAL_OP_TRAP_EN
        for (int t = 0; t < 3; t++) pushOne(11);
`endif
      end
    endcase
  endfunction

  task automatic checkCycle(input int st);
    checkVal($sformatf("state st%0d", st), 64'(State), 64'(st));
    checkVal($sformatf("ctrl st%0d", st), 64'(dutCtrl()), 64'(expCtrl(st, MemReady, Zero)));
    checkVal($sformatf("immSrc op%0h", Op), 64'(ImmSrc), 64'(immExp(Op)));
    checkVal($sformatf("retireCnt st%0d", st), 64'(RetireCnt), 64'(expCnt));
    checkVal($sformatf("illegal st%0d", st), 64'(Illegal), 64'(st == 11));
  endtask

  task automatic checkReset();
    checkVal("rst state", 64'(State), 64'd0);
    checkVal("rst ctrl", 64'(dutCtrl()), 64'(RESET_WORD));
    checkVal("rst retireCnt", 64'(RetireCnt), 64'd0);
    checkVal("rst illegal", 64'(Illegal), 64'd0);
  endtask

  // Entered at a falling edge; zMode < 0 drives random Zero. abortAfter > 0
  // returns mid-cycle after that many checked cycles.
  task automatic runInstr(input logic [6:0] op, input int fw, input int mw,
                          input int zMode, input int abortAfter);
    buildTrace(op, fw, mw);
    foreach (trace[i]) begin
      MemReady = trace[i].rdy;
      Zero     = (zMode < 0) ? 1'($urandom) : 1'(zMode);
      Op       = (trace[i].st == 1 || trace[i].st == 2) ? op : 7'($urandom);
      #1;
      checkCycle(trace[i].st);
      if (abortAfter > 0 && i == abortAfter - 1) return;
      if (i == trace.size() - 1 && isLegal(op)) expCnt = expCnt + 1'b1;
      @(negedge clk);
    end
  endtask

  function automatic logic [6:0] randOp(input bit allowIllegal);
    logic [6:0] ops [6];
    logic [6:0] op;
    ops = '{LW, SW, RT, IT, BQ, JL};
    if (allowIllegal && $urandom_range(0, 7) == 0) begin
      do op = 7'($urandom); while (isLegal(op));
      return op;
    end
    return ops[$urandom_range(0, 5)];
  endfunction

  initial begin
    bit allowIllegal;
    rst      = 1'b1;
    MemReady = 1'b1;
    Zero     = 1'b1;
    Op       = RT;
    expCnt   = '0;
    #1 checkReset();
    @(negedge clk);
    #1 checkReset();
    @(negedge clk);
    rst = 1'b0;

    runInstr(LW, 0, 0, -1, 0);
    runInstr(RT, 0, 0, -1, 3);
    #2 rst = 1'b1;
    expCnt = '0;
    #1 checkReset();
    repeat (2) begin
      @(negedge clk);
      #1 checkReset();
    end
    @(negedge clk);
    rst = 1'b0;

    runInstr(SW, 0, 3, -1, 0);
    runInstr(BQ, 0, 0, 1, 0);
    runInstr(BQ, 1, 0, 0, 0);
    runInstr(JL, 2, 0, -1, 0);
    runInstr(IT, 0, 0, -1, 0);
    runInstr(LW, 1, 2, -1, 0);
`ifndef ILLEGAL_OP_TRAP_EN
    runInstr(7'b1111111, 0, 0, -1, 0);
    allowIllegal = 1'b1;
`else
    allowIllegal = 1'b0;
`endif

    for (int n = 0; n < 300; n++) begin
      runInstr(randOp(allowIllegal), $urandom_range(0, 3) * $urandom_range(0, 1),
               $urandom_range(0, 3) * $urandom_range(0, 1), -1, 0);
    end

    MemReady = 1'b0;
    #1;
    checkVal("final state", 64'(State), 64'd0);
    checkVal("final retireCnt", 64'(RetireCnt), 64'(expCnt));

`ifdef ILLEGAL_OP_TRAP_EN
    @(negedge clk);
    runInstr(7'b1111111, 0, 0, -1, 0);
    MemReady = 1'b1;
    #1 checkVal("trap held", 64'(State), 64'd11);
    rst = 1'b1;
    expCnt = '0;
    #1 checkReset();
    @(negedge clk);
    rst = 1'b0;
    runInstr(BQ, 0, 0, 1, 0);
`endif

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
